// File: rtl/flash_pkg.sv
// Shared types and constants for the SPI flash read arbiter.
// Frame layout: 8-bit command, 24-bit address, 32 data bits, MSB first on the wire.
package flash_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        WAKE  = 2'd3
    } state_t;

    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_WAKE   = 8'hAB;
    localparam int         FRAME_BITS = 64;

    // Flash returns the lowest-addressed byte first; the CPU wants it in bits [7:0].
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/flash_rr_arb.sv
// Two-way round-robin grant; combinational grant, pointer registered when accept is high.
// Reset leaves the pointer at "port 1 served last" so port 0 wins the first tie.
module flash_rr_arb (
    input  logic CLK_CPU,
    input  logic resetn,
    input  logic req0,
    input  logic req1,
    input  logic accept,
    output logic gnt_id,
    output logic gnt_vld
);

    logic last;

    assign gnt_vld = req0 | req1;
    assign gnt_id  = (req0 && req1) ? ~last : req1;

    always_ff @(posedge CLK_CPU or negedge resetn) begin
        if (!resetn) begin
            last <= 1'b1;
        end else if (accept && gnt_vld) begin
            last <= gnt_id;
        end
    end

endmodule

// File: rtl/flash_read_arbiter.sv
// Shares one SPI flash (mode 0 READ 0x03, one LE word per frame) between fetch port 0 and load port 1, round-robin.
// Ack 129 cycles after grant at SCK_HALF=1, requesters hold req until ack; FLASH_WAKEUP_EN adds a 0xAB wakeup after reset.
module flash_read_arbiter
    import flash_pkg::*;
#(
    parameter logic [23:0] ADDR_OFFSET = 24'h050000,
    parameter int          SCK_HALF    = 1,
    parameter int          WAKE_WAIT   = 64
) (
    input  logic        CLK_CPU,
    input  logic        resetn,
    input  logic        req0,
    input  logic [23:0] addr0,
    output logic        ack0,
    input  logic        req1,
    input  logic [23:0] addr1,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        SPI_CS,
    output logic        SPI_SCK,
    output logic        SPI_SI,
    input  logic        SPI_SO
);

    localparam int HW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    // One counter serves both the bit index and the wakeup hold time.
    localparam int CW = (WAKE_WAIT > 63) ? $clog2(WAKE_WAIT + 1) : 6;
    localparam logic [HW-1:0] HALF_LAST = HW'(SCK_HALF - 1);

    state_t        state;
    logic [63:0]   tx;
    logic [31:0]   rx;
    logic [HW-1:0] half_cnt;
    logic          high_ph;
    logic [CW-1:0] cnt;
    logic          owner;
    logic          gnt_id;
    logic          gnt_vld;
    logic          idle;
    logic          bit_end;
    logic [31:0]   rx_nxt;
    logic [23:0]   sel_addr;
`ifdef FLASH_WAKEUP_EN
    logic          wake_wait;
`endif

    assign idle     = (state == IDLE);
    assign bit_end  = high_ph && (half_cnt == HALF_LAST);
    assign rx_nxt   = {rx[30:0], SPI_SO};
    assign sel_addr = gnt_id ? addr1 : addr0;

    flash_rr_arb u_arb (
        .CLK_CPU (CLK_CPU),
        .resetn  (resetn),
        .req0    (req0),
        .req1    (req1),
        .accept  (idle),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld)
    );

    always_ff @(posedge CLK_CPU or negedge resetn) begin
        if (!resetn) begin
            state    <= `ifdef FLASH_WAKEUP_EN WAKE `else IDLE `endif ;
`ifdef FLASH_WAKEUP_EN
            tx        <= {CMD_WAKE, 56'd0};
            wake_wait <= 1'b0;
`else
            tx        <= '0;
`endif
            rx       <= '0;
            half_cnt <= '0;
            high_ph  <= 1'b0;
            cnt      <= '0;
            owner    <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata    <= '0;
            busy     <= 1'b0;
            SPI_CS   <= 1'b1;
            SPI_SCK  <= 1'b0;
            SPI_SI   <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;

            // CS is low only while a frame is on the wire, so it gates the bit engine.
            if (!SPI_CS) begin
                if (half_cnt != HALF_LAST) begin
                    half_cnt <= half_cnt + HW'(1);
                end else begin
                    half_cnt <= '0;
                    high_ph  <= ~high_ph;
                    SPI_SCK  <= ~high_ph;
                    if (high_ph) begin
                        rx     <= rx_nxt;
                        tx     <= {tx[62:0], 1'b0};
                        SPI_SI <= tx[62];
                        cnt    <= cnt + CW'(1);
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        state    <= SHIFT;
                        busy     <= 1'b1;
                        owner    <= gnt_id;
                        tx       <= {CMD_READ, sel_addr + ADDR_OFFSET, 32'd0};
                        cnt      <= '0;
                        half_cnt <= '0;
                        high_ph  <= 1'b0;
                        SPI_CS   <= 1'b0;
                        SPI_SCK  <= 1'b0;
                        SPI_SI   <= CMD_READ[7];
                    end
                end
                SHIFT: begin
                    if (bit_end && cnt == CW'(FRAME_BITS - 1)) begin
                        state  <= DONE;
                        SPI_CS <= 1'b1;
                        SPI_SI <= 1'b0;
                        rdata  <= bswap32(rx_nxt);
                        ack0   <= ~owner;
                        ack1   <= owner;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
`ifdef FLASH_WAKEUP_EN
                WAKE: begin
                    busy <= 1'b1;
                    if (wake_wait) begin
                        if (cnt == CW'(WAKE_WAIT - 1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else if (SPI_CS) begin
                        SPI_CS <= 1'b0;
                        SPI_SI <= tx[63];
                    end else if (bit_end && cnt == CW'(7)) begin
                        SPI_CS    <= 1'b1;
                        SPI_SI    <= 1'b0;
                        wake_wait <= 1'b1;
                        cnt       <= '0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter: table of READ transactions plus reset/tie/offset sequences.
// A behavioural mode-0 flash model captures the frame and serves a 32-bit data stream.
module tb_flash_read_arbiter;

    logic        CLK_CPU;
    logic        resetn;
    logic        req0, req1, ack0, ack1, busy;
    logic [23:0] addr0, addr1;
    logic [31:0] rdata;
    logic        SPI_CS, SPI_SCK, SPI_SI, so;

    logic        req0b, req1b, ack0b, ack1b, busyb;
    logic [23:0] addr0b, addr1b;
    logic [31:0] rdatab;
    logic        csb, sckb, sib, sob;

    int total = 0;
    int bad   = 0;

    flash_read_arbiter dut (
        .CLK_CPU(CLK_CPU), .resetn(resetn),
        .req0(req0), .addr0(addr0), .ack0(ack0),
        .req1(req1), .addr1(addr1), .ack1(ack1),
        .rdata(rdata), .busy(busy),
        .SPI_CS(SPI_CS), .SPI_SCK(SPI_SCK), .SPI_SI(SPI_SI), .SPI_SO(so)
    );

    flash_read_arbiter #(.ADDR_OFFSET(24'h000004), .SCK_HALF(2)) dut2 (
        .CLK_CPU(CLK_CPU), .resetn(resetn),
        .req0(req0b), .addr0(addr0b), .ack0(ack0b),
        .req1(req1b), .addr1(addr1b), .ack1(ack1b),
        .rdata(rdatab), .busy(busyb),
        .SPI_CS(csb), .SPI_SCK(sckb), .SPI_SI(sib), .SPI_SO(sob)
    );

    initial CLK_CPU = 1'b0;
    always #5 CLK_CPU = ~CLK_CPU;

    // Flash model: CS fall restarts the frame, SCK rise captures SI, SCK fall presents the next data bit.
    logic [63:0] cap;
    int          nb;
    logic [31:0] fstream;
    always @(negedge SPI_CS or posedge SPI_SCK) begin
        if (SPI_SCK) begin
            cap = {cap[62:0], SPI_SI};
            nb  = nb + 1;
        end else begin
            cap = '0;
            nb  = 0;
        end
    end
    always @(negedge SPI_SCK) begin
        if (!SPI_CS && nb >= 32 && nb < 64) so = fstream[63 - nb];
    end

    logic [63:0] cap2;
    int          nb2;
    always @(negedge csb or posedge sckb) begin
        if (sckb) begin
            cap2 = {cap2[62:0], sib};
            nb2  = nb2 + 1;
        end else begin
            cap2 = '0;
            nb2  = 0;
        end
    end

    typedef struct {
        logic        r0;
        logic        r1;
        logic [23:0] a0;
        logic [23:0] a1;
        logic [31:0] flash;
        logic        chk_gap;
        logic        port;
        logic [23:0] fa;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic after_reset();
`ifdef FLASH_WAKEUP_EN
        int n;
        n = 0;
        @(negedge CLK_CPU);
        chk("wake_cs_low", {63'd0, SPI_CS}, 64'd0);
        chk("wake_busy", {63'd0, busy}, 64'd1);
        while (!SPI_CS && n < 100) begin
            n++;
            @(negedge CLK_CPU);
        end
        chk("wake_len", n, 16);
        chk("wake_cmd", cap[7:0], 8'hAB);
        repeat (63) @(negedge CLK_CPU);
        chk("wake_hold_cs", {63'd0, SPI_CS}, 64'd1);
        chk("wake_hold_busy", {63'd0, busy}, 64'd1);
        @(negedge CLK_CPU);
        chk("wake_idle_busy", {63'd0, busy}, 64'd0);
`endif
    endtask

    // One frame on the default instance: CS-high samples before it, CS-low length, acks and rdata at
    // the CS-rise sample, and the sample after that (ack must be gone, block back in IDLE).
    task automatic run_frame(output int gap, output int len, output logic g0, output logic g1,
                             output logic [31:0] rd, output logic [31:0] rd_start,
                             output logic bmid, output logic tail);
        gap = 0; len = 0; g0 = 0; g1 = 0; rd = '0; rd_start = '0; bmid = 0; tail = 1;
        @(negedge CLK_CPU);
        while (SPI_CS && gap < 300) begin
            gap++;
            @(negedge CLK_CPU);
        end
        if (SPI_CS) return;
        rd_start = rdata;
        bmid     = busy;
        while (!SPI_CS && len < 1000) begin
            len++;
            @(negedge CLK_CPU);
        end
        g0 = ack0;
        g1 = ack1;
        rd = rdata;
        @(negedge CLK_CPU);
        tail = ack0 | ack1 | busy;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        int          gap, len;
        logic        g0, g1, bmid, tail, ok, seen;
        logic [31:0] rd, rs, prev;

        resetn = 0; req0 = 0; req1 = 0; addr0 = '0; addr1 = '0;
        fstream = '0; so = 0;
        req0b = 0; req1b = 0; addr0b = '0; addr1b = '0; sob = 1;

        repeat (3) @(negedge CLK_CPU);
        chk("rst_cs", {63'd0, SPI_CS}, 64'd1);
        chk("rst_sck", {63'd0, SPI_SCK}, 64'd0);
        chk("rst_si", {63'd0, SPI_SI}, 64'd0);
        chk("rst_ack", {62'd0, ack1, ack0}, 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        resetn = 1;
        after_reset();

        //          r0    r1    a0           a1           flash         gap   port  flash addr   rdata
        tbl[0] = '{1'b1, 1'b0, 24'h000100, 24'h000000, 32'h11223344, 1'b0, 1'b0, 24'h050100, 32'h44332211};
        tbl[1] = '{1'b1, 1'b1, 24'h000200, 24'h000300, 32'hAABBCCDD, 1'b1, 1'b1, 24'h050300, 32'hDDCCBBAA};
        tbl[2] = '{1'b1, 1'b1, 24'h000200, 24'h000300, 32'h01020304, 1'b1, 1'b0, 24'h050200, 32'h04030201};
        tbl[3] = '{1'b1, 1'b1, 24'h000200, 24'hFB0001, 32'h80000001, 1'b1, 1'b1, 24'h000001, 32'h01000080};
        tbl[4] = '{1'b0, 1'b1, 24'h000000, 24'h123456, 32'hFFFFFFFF, 1'b1, 1'b1, 24'h173456, 32'hFFFFFFFF};
        tbl[5] = '{1'b1, 1'b0, 24'hFFFFFF, 24'h000000, 32'h00000000, 1'b1, 1'b0, 24'h04FFFF, 32'h00000000};

        prev = '0;
        for (int i = 0; i < 6; i++) begin
            req0 = tbl[i].r0; req1 = tbl[i].r1;
            addr0 = tbl[i].a0; addr1 = tbl[i].a1;
            fstream = tbl[i].flash;
            run_frame(gap, len, g0, g1, rd, rs, bmid, tail);
            chk($sformatf("v%0d_ack0", i), {63'd0, g0}, {63'd0, ~tbl[i].port});
            chk($sformatf("v%0d_ack1", i), {63'd0, g1}, {63'd0, tbl[i].port});
            chk($sformatf("v%0d_rdata", i), rd, tbl[i].rd);
            chk($sformatf("v%0d_frame", i), cap, {8'h03, tbl[i].fa, 32'h0});
            chk($sformatf("v%0d_cs_low_len", i), len, 128);
            chk($sformatf("v%0d_ack_tail", i), {63'd0, tail}, 64'd0);
            chk($sformatf("v%0d_rdata_hold", i), rs, prev);
            chk($sformatf("v%0d_busy_mid", i), {63'd0, bmid}, 64'd1);
            if (tbl[i].chk_gap) chk($sformatf("v%0d_cs_gap_extra", i), gap, 0);
            prev = tbl[i].rd;
        end
        req0 = 0; req1 = 0;

        // Simultaneous requests right after reset: port 0 first, then port 1 back-to-back.
        resetn = 0;
        @(negedge CLK_CPU);
        resetn = 1;
        after_reset();
        req0 = 1; req1 = 1; addr0 = 24'h000010; addr1 = 24'h000020; fstream = 32'h12345678;
        run_frame(gap, len, g0, g1, rd, rs, bmid, tail);
        chk("tie_first_ack0", {62'd0, g1, g0}, 64'd1);
        chk("tie_first_frame", cap, {8'h03, 24'h050010, 32'h0});
        chk("tie_first_rdata", rd, 32'h78563412);
        run_frame(gap, len, g0, g1, rd, rs, bmid, tail);
        chk("tie_second_ack1", {62'd0, g1, g0}, 64'd2);
        chk("tie_second_frame", cap, {8'h03, 24'h050020, 32'h0});
        chk("tie_cs_gap_extra", gap, 0);
        req0 = 0; req1 = 0;

        // Reset during bit 20 of a frame, then the still-held request restarts cleanly.
        req0 = 1; addr0 = 24'h000100; fstream = 32'h11223344;
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK_CPU);
            if (!SPI_CS) begin
                ok = 1;
                break;
            end
        end
        chk("abort_cs_fell", {63'd0, ok}, 64'd1);
        repeat (40) @(negedge CLK_CPU);
        resetn = 0;
        #1;
        chk("abort_cs", {63'd0, SPI_CS}, 64'd1);
        chk("abort_sck", {63'd0, SPI_SCK}, 64'd0);
        chk("abort_si", {63'd0, SPI_SI}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        seen = ack0 | ack1;
        repeat (3) begin
            @(negedge CLK_CPU);
            seen = seen | ack0 | ack1;
        end
        chk("abort_no_ack", {63'd0, seen}, 64'd0);
        resetn = 1;
        after_reset();
        run_frame(gap, len, g0, g1, rd, rs, bmid, tail);
        chk("restart_ack0", {62'd0, g1, g0}, 64'd1);
        chk("restart_frame", cap, {8'h03, 24'h050100, 32'h0});
        chk("restart_len", len, 128);
        chk("restart_rdata", rd, 32'h44332211);
        req0 = 0;

        // Second instance: offset 4, SCK_HALF=2, address wrap, request dropped mid-frame.
        addr1b = 24'hFFFFFE; req1b = 1;
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK_CPU);
            if (!csb) begin
                ok = 1;
                break;
            end
        end
        chk("off_cs_fell", {63'd0, ok}, 64'd1);
        chk("off_busy", {63'd0, busyb}, 64'd1);
        req1b = 0;
        len = 0;
        while (!csb && len < 1000) begin
            len++;
            @(negedge CLK_CPU);
        end
        chk("off_cs_low_len", len, 256);
        chk("off_acks", {62'd0, ack1b, ack0b}, 64'd2);
        chk("off_frame", cap2, {8'h03, 24'h000002, 32'h0});
        chk("off_sck_edges", nb2, 64);
        chk("off_rdata", rdatab, 32'hFFFFFFFF);
        @(negedge CLK_CPU);
        chk("off_ack_tail", {62'd0, ack1b, ack0b}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flash_read_arbiter.md
Name: flash_read_arbiter

Overview:
- Shares the board's single SPI flash between two CPU requesters: port 0 is instruction fetch and port 1 is data load.
- Runs standard READ (0x03) transactions, each returning one 32-bit little-endian word.
- Sits inside CPU between the fetch/LSU logic and the top-level SPI_CS/SPI_SCK/SPI_SI/SPI_SO pins.
- Uses round-robin arbitration, one transaction at a time, SPI mode 0.

Parameters:
- ADDR_OFFSET, default 24'h050000: added to the requester address to form the flash address (user area above the bitstream).
- SCK_HALF, default 1: CLK_CPU cycles per SCK phase, >=1. SCK period = 2*SCK_HALF cycles.
- WAKE_WAIT, default 64: CLK_CPU cycles CS is held high after wakeup (FLASH_WAKEUP_EN only).

Ports:
- CLK_CPU  in  1  sole clock.
- resetn  in  1  asynchronous active-low reset.
- req0  in  1  port 0 request; held until ack0.
- addr0  in  24  port 0 byte address; stable while req0 is high.
- ack0  out  1  one-cycle pulse; rdata is valid for port 0 in that cycle.
- req1  in  1  port 1 request.
- addr1  in  24  port 1 byte address.
- ack1  out  1  one-cycle pulse for port 1.
- rdata  out  32  read word; holds its value until the next ack.
- busy  out  1  high whenever the block is not in IDLE.
- SPI_CS  out  1  flash chip select, active low.
- SPI_SCK  out  1  SPI clock, idles low.
- SPI_SI  out  1  MOSI.
- SPI_SO  in  1  MISO.

Behaviour:
- Reset values: SPI_CS=1, SPI_SCK=0, SPI_SI=0, ack0=ack1=0, rdata=0, busy=0, RR pointer favours port 0, state IDLE.
- States: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE: if req0 or req1 is high, grant one port and latch:
  - tx = {8'h03, (addr+ADDR_OFFSET) mod 2^24}. The 24-bit sum wraps and the carry is dropped.
  - grant id; bit counter = 0.
  - SPI_CS=0 from the next cycle; go to SHIFT.
- Arbitration:
  - Only one requester: grant it.
  - Both requesting: grant the port not served last.
  - The pointer updates at grant.
- SHIFT, 64 bits (8 command + 24 address + 32 data), each bit = low phase then high phase, SCK_HALF cycles each:
  - Low phase: SCK=0; SI = tx MSB, driven at phase start.
  - High phase: SCK=1; SO is sampled on the last cycle of the phase into the rx shift register (MSB first within each byte).
  - tx shifts left after each high phase. SI=0 during the data bits.
  - After bit 63: go to DONE.
- DONE:
  - SPI_CS=1, SCK=0.
  - rdata = {b3,b2,b1,b0}, where b0 is the first data byte received (lowest address).
  - ack of the granted port pulses in this cycle; go to IDLE.
- Latency at SCK_HALF=1: req sampled in IDLE at edge N; CS low N+1..N+128; ack and rdata at N+129.
- Minimum CS-high gap between transactions is 2 cycles (DONE + IDLE).
- Dropping req mid-transaction: the transaction still completes and the ack still pulses. Requesters must ignore a stale ack.
- Address alignment is not checked; any byte address is legal.
- Reset asserted mid-operation: all outputs return to reset values asynchronously and no ack is issued. A still-pending request restarts from the command byte after release.
- No output glitches: CS, SCK and SI are all registered.

Optional Feature:
- FLASH_WAKEUP_EN defined:
  - After reset the block enters WAKE instead of IDLE and sends the 8-bit command 0xAB (release from deep power-down), same bit timing as SHIFT.
  - CS then stays high for WAKE_WAIT cycles, then the block goes to IDLE.
  - busy=1 throughout; requests are not granted until IDLE.
- Undefined: no WAKE state; the block enters IDLE directly after reset.

Decomposition:
- Package flash_pkg:
  - state enum (IDLE, SHIFT, DONE, WAKE)
  - CMD_READ = 8'h03, CMD_WAKE = 8'hAB
  - FRAME_BITS = 64
- Sub-module flash_rr_arb: 2-way round-robin grant with registered last-served pointer; inputs req0/req1/accept, output grant id and valid.
- The shift/phase counters remain in the top module.

Test Plan:
- Port 0 request, addr0=24'h000100, default offset -> SI bytes 03 05 01 00; flash model returns 11 22 33 44 -> ack0 at N+129, rdata=32'h44332211, CS high after.
- req0 and req1 raised together after reset -> port 0 served first, then port 1; CS high exactly 2 cycles between frames; one ack0 pulse then one ack1 pulse.
- Both ports held high continuously for 4 transactions -> grants alternate 0,1,0,1; each ack is exactly 1 cycle.
- Reset pulsed at bit 20 of SHIFT -> CS=1 and SCK=0 immediately, no ack; after release, the held req0 produces a complete new frame starting with 0x03.
- ADDR_OFFSET=24'h000004, addr1=24'hFFFFFE -> transmitted address 24'h000002.
- FLASH_WAKEUP_EN with req0 high from reset -> 0xAB frame, then CS high 64 cycles, then the READ frame; ack0 arrives after the wakeup.
